// File: rtl/storage_pkg.sv
// rtl/storage_pkg.sv - shared widths, NOP constant and fixed program image for the storage block
package storage_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

    // Boot program: builds x1..x5 and stores two results to data memory.
    localparam logic [DATA_W-1:0] ROM_IMAGE [DEPTH] = '{
        32'h0050_0093, 32'h0070_0113, 32'h0020_81B3, 32'h0030_2223,
        32'h0011_8213, 32'h0040_2423, 32'h0032_02B3, NOP,
        NOP, NOP, NOP, NOP, NOP, NOP, NOP, NOP,
        NOP, NOP, NOP, NOP, NOP, NOP, NOP, NOP,
        NOP, NOP, NOP, NOP, NOP, NOP, NOP, NOP
    };

endpackage

// File: rtl/storage_array.sv
// rtl/storage_array.sv - async-reset 32x32 flop array with one write port and all words exposed
module storage_array
    import storage_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DEPTH*DATA_W-1:0]  words
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr_ok;

    // SKIP_ZERO keeps word 0 hardwired to zero for the x0 register.
    always_comb begin
        mem_d = mem_q;
        wr_ok = wr_en && !(SKIP_ZERO && (wr_addr == '0));
        if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_words
        assign words[g*DATA_W +: DATA_W] = mem_q[g];
    end

endmodule

// File: rtl/cpu_storage_unit.sv
// rtl/cpu_storage_unit.sv - regfile, instruction ROM and data RAM for the single-cycle RV32 datapath
module cpu_storage_unit #(
    parameter int DATA_W = storage_pkg::DATA_W,
    parameter int ADDR_W = storage_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rom_pc,
    output logic [DATA_W-1:0] rom_instr,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_data,
    input  logic              ram_wren,
    output logic [DATA_W-1:0] ram_q
);
    import storage_pkg::*;

    logic [DEPTH*DATA_W-1:0] rf_flat;
    logic [DEPTH*DATA_W-1:0] ram_flat;
    logic [DATA_W-1:0]       rf_word  [DEPTH];
    logic [DATA_W-1:0]       ram_word [DEPTH];
    logic [DATA_W-1:0]       ram_q_d;
    logic [DATA_W-1:0]       ram_q_q;

    storage_array #(.SKIP_ZERO(1'b1)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (write_enable),
        .wr_addr (write_reg),
        .wr_data (write_data),
        .words   (rf_flat)
    );

    storage_array #(.SKIP_ZERO(1'b0)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_wren),
        .wr_addr (ram_address),
        .wr_data (ram_data),
        .words   (ram_flat)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
        assign rf_word[g]  = rf_flat[g*DATA_W +: DATA_W];
        assign ram_word[g] = ram_flat[g*DATA_W +: DATA_W];
    end

    assign read_data1 = (read_reg1 == '0) ? '0 : rf_word[read_reg1];
    assign read_data2 = (read_reg2 == '0) ? '0 : rf_word[read_reg2];

    assign rom_instr = ROM_IMAGE[rom_pc];

    // Sampled from the pre-edge array, so a same-address write returns the old word.
    always_comb begin
        ram_q_d = ram_word[ram_address];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_q_q <= '0;
        end else begin
            ram_q_q <= ram_q_d;
        end
    end

    assign ram_q = ram_q_q;

endmodule

// File: tb/tb_cpu_storage_unit.sv
// tb/tb_cpu_storage_unit.sv - randomized self-checking bench for cpu_storage_unit
module tb_cpu_storage_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rom_pc = '0;
    logic [31:0] rom_instr;
    logic [4:0]  read_reg1 = '0;
    logic [4:0]  read_reg2 = '0;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [4:0]  write_reg = '0;
    logic [31:0] write_data = '0;
    logic        write_enable = 1'b0;
    logic [4:0]  ram_address = '0;
    logic [31:0] ram_data = '0;
    logic        ram_wren = 1'b0;
    logic [31:0] ram_q;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] ref_rf  [32];
    logic [31:0] ref_ram [32];
    logic [31:0] ref_q;

    cpu_storage_unit dut (
        .clk          (clk),
        .rst          (rst),
        .rom_pc       (rom_pc),
        .rom_instr    (rom_instr),
        .read_reg1    (read_reg1),
        .read_reg2    (read_reg2),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .write_enable (write_enable),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_model(input int pc);
        case (pc)
            0: return 32'h00500093;
            1: return 32'h00700113;
            2: return 32'h002081B3;
            3: return 32'h00302223;
            4: return 32'h00118213;
            5: return 32'h00402423;
            6: return 32'h003202B3;
            default: return 32'h00000013;
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            ref_rf[i]  = '0;
            ref_ram[i] = '0;
        end
        ref_q = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied, then clock the DUT.
    task automatic tick();
        logic [31:0] old_word;
        old_word = ref_ram[ram_address];
        if (!rst) begin
            if (write_enable && write_reg != 0) ref_rf[write_reg] = write_data;
            if (ram_wren) ref_ram[ram_address] = ram_data;
            ref_q = old_word;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        for (int i = 0; i < 32; i++) begin
            read_reg1 = i[4:0];
            read_reg2 = 5'(31 - i);
            #1;
            vectors++;
            if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_regs idx=%0d got %h/%h want 0/0", i, read_data1, read_data2);
            end
        end
        vectors++;
        if (ram_q !== 32'h0) begin
            errors++;
            $display("FAIL reset_ram_q got %h want 0", ram_q);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ram_address = 5'($urandom_range(0, 31));
            tick();
            vectors++;
            if (ram_q !== 32'h0) begin
                errors++;
                $display("FAIL reset_ram_read addr=%0d got %h want 0", ram_address, ram_q);
            end
        end
    endtask

    task automatic test_regfile();
        write_enable = 1'b1;
        write_reg = 5'd1;
        write_data = 32'd5;
        read_reg1 = 5'd1;
        #1;
        vectors++;
        if (read_data1 !== 32'h0) begin
            errors++;
            $display("FAIL no_bypass got %h want 0", read_data1);
        end
        tick();
        write_reg = 5'd2;
        write_data = 32'd7;
        tick();
        write_enable = 1'b0;
        read_reg1 = 5'd1;
        read_reg2 = 5'd2;
        #1;
        vectors++;
        if (read_data1 !== 32'd5 || read_data2 !== 32'd7) begin
            errors++;
            $display("FAIL regfile_rw got %h/%h want 5/7", read_data1, read_data2);
        end
        read_reg2 = 5'd1;
        #1;
        vectors++;
        if (read_data1 !== 32'd5 || read_data2 !== 32'd5) begin
            errors++;
            $display("FAIL same_reg_both_ports got %h/%h want 5/5", read_data1, read_data2);
        end
    endtask

    task automatic test_x0();
        write_enable = 1'b1;
        write_reg = 5'd0;
        write_data = 32'hDEADBEEF;
        tick();
        write_enable = 1'b0;
        read_reg1 = 5'd0;
        #1;
        vectors++;
        if (read_data1 !== 32'h0) begin
            errors++;
            $display("FAIL x0_write got %h want 0", read_data1);
        end
    endtask

    task automatic test_rom();
        logic [31:0] expect_tbl [10];
        int          pcs        [10];
        expect_tbl = '{32'h00500093, 32'h00700113, 32'h002081B3, 32'h00302223, 32'h00118213,
                       32'h00402423, 32'h003202B3, 32'h00000013, 32'h00000013, 32'h00000013};
        pcs = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 31};
        for (int i = 0; i < 10; i++) begin
            rom_pc = pcs[i][4:0];
            #1;
            vectors++;
            if (rom_instr !== expect_tbl[i]) begin
                errors++;
                $display("FAIL rom pc=%0d got %h want %h", pcs[i], rom_instr, expect_tbl[i]);
            end
        end
    endtask

    task automatic test_ram();
        ram_address = 5'd4;
        ram_data = 32'd12;
        ram_wren = 1'b1;
        tick();
        ram_wren = 1'b0;
        tick();
        vectors++;
        if (ram_q !== 32'd12) begin
            errors++;
            $display("FAIL ram_load got %h want 12", ram_q);
        end
        ram_address = 5'd8;
        ram_data = 32'd13;
        ram_wren = 1'b1;
        tick();
        vectors++;
        if (ram_q !== 32'd0) begin
            errors++;
            $display("FAIL ram_rdw_old got %h want 0", ram_q);
        end
        ram_wren = 1'b0;
        tick();
        vectors++;
        if (ram_q !== 32'd13) begin
            errors++;
            $display("FAIL ram_rdw_new got %h want 13", ram_q);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            write_enable = 1'($urandom_range(0, 1));
            write_reg    = 5'($urandom_range(0, 31));
            write_data   = $urandom;
            ram_wren     = 1'($urandom_range(0, 1));
            ram_address  = 5'($urandom_range(0, 31));
            ram_data     = $urandom;
            read_reg1    = 5'($urandom_range(0, 31));
            read_reg2    = ($urandom_range(0, 3) == 0) ? read_reg1 : 5'($urandom_range(0, 31));
            rom_pc       = 5'($urandom_range(0, 31));
            #1;
            vectors++;
            if (read_data1 !== ref_rf[read_reg1] || read_data2 !== ref_rf[read_reg2]) begin
                errors++;
                $display("FAIL rand_read r%0d/r%0d got %h/%h want %h/%h", read_reg1, read_reg2,
                         read_data1, read_data2, ref_rf[read_reg1], ref_rf[read_reg2]);
            end
            vectors++;
            if (rom_instr !== rom_model(int'(rom_pc))) begin
                errors++;
                $display("FAIL rand_rom pc=%0d got %h want %h", rom_pc, rom_instr, rom_model(int'(rom_pc)));
            end
            tick();
            vectors++;
            if (ram_q !== ref_q) begin
                errors++;
                $display("FAIL rand_ram_q got %h want %h", ram_q, ref_q);
            end
        end
        write_enable = 1'b0;
        ram_wren = 1'b0;
    endtask

    task automatic test_async_reset();
        int nonzero;
        nonzero = 0;
        for (int i = 1; i < 32; i++) if (ref_rf[i] != 0) nonzero++;
        vectors++;
        if (nonzero == 0) begin
            errors++;
            $display("FAIL async_precondition got %0d nonzero regs want >0", nonzero);
        end
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        vectors++;
        if (ram_q !== 32'h0) begin
            errors++;
            $display("FAIL async_ram_q got %h want 0", ram_q);
        end
        for (int i = 0; i < 32; i++) begin
            read_reg1 = i[4:0];
            read_reg2 = i[4:0];
            #0.1;
            vectors++;
            if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
                errors++;
                $display("FAIL async_regs idx=%0d got %h/%h want 0/0", i, read_data1, read_data2);
            end
        end
        write_enable = 1'b1;
        write_reg = 5'd3;
        write_data = 32'h1234_5678;
        ram_wren = 1'b1;
        ram_address = 5'd3;
        ram_data = 32'hCAFE_F00D;
        read_reg1 = 5'd3;
        tick();
        vectors++;
        if (read_data1 !== 32'h0) begin
            errors++;
            $display("FAIL write_in_reset got %h want 0", read_data1);
        end
        write_enable = 1'b0;
        ram_wren = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ram_address = a[4:0];
            tick();
            vectors++;
            if (ram_q !== ref_q) begin
                errors++;
                $display("FAIL async_ram_word addr=%0d got %h want %h", a, ram_q, ref_q);
            end
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_regfile();
        test_x0();
        test_rom();
        test_ram();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cpu_storage_unit.md
Name: cpu_storage_unit

Overview:
Storage block for the single-cycle RV32 datapath. Bundles three sub-blocks behind one clock and one reset:
- 32x32 register file (regfile semantics).
- 32-entry fixed-program instruction ROM.
- 32x32 single-port data RAM (fakeram semantics).

The processor top drives PC, register indices, ALU result and store data into it, and consumes instruction, operands and load data.

Parameters:
- DATA_W, 32, word width of regfile, ROM and RAM. Only the default is supported.
- ADDR_W, 5, index width of all three arrays; depth = 2**ADDR_W = 32.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_pc  in  5  instruction word address.
- rom_instr  out  32  instruction at rom_pc; combinational.
- read_reg1  in  5  regfile read index A.
- read_reg2  in  5  regfile read index B.
- read_data1  out  32  x[read_reg1]; combinational.
- read_data2  out  32  x[read_reg2]; combinational.
- write_reg  in  5  regfile write index.
- write_data  in  32  regfile write value.
- write_enable  in  1  regfile write strobe.
- ram_address  in  5  RAM word address.
- ram_data  in  32  RAM write value.
- ram_wren  in  1  RAM write strobe.
- ram_q  out  32  RAM read data; registered.

Behaviour:
Reset (rst high, asynchronous):
- All 32 registers, all 32 RAM words and the ram_q register clear to 0 immediately.
- While rst is high, writes are ignored.

Regfile:
- Reads are combinational: read_data1 = x[read_reg1], read_data2 = x[read_reg2].
- Index 0 always reads 0.
- Write: on posedge clk with write_enable=1 and write_reg!=0, x[write_reg] <= write_data.
- Writes to x0 are discarded.
- No write-to-read bypass: a read of write_reg shows the old value until after the edge.
- Both read ports may address the same register.

ROM:
- Combinational; rom_instr = ROM[rom_pc]. Contents are fixed constants, not writable.
- Word 0: 0x00500093 (addi x1,x0,5)
- Word 1: 0x00700113 (addi x2,x0,7)
- Word 2: 0x002081B3 (add x3,x1,x2)
- Word 3: 0x00302223 (sw x3,4(x0))
- Word 4: 0x00118213 (addi x4,x3,1)
- Word 5: 0x00402423 (sw x4,8(x0))
- Word 6: 0x003202B3 (add x5,x4,x3)
- Words 7..31: 0x00000013 (nop)

RAM:
- Word-addressed by ram_address, 5 bits; the caller passes alu_res[4:0].
- Write: on posedge with ram_wren=1, M[ram_address] <= ram_data.
- Read: on every posedge, ram_q <= M[ram_address]. Load data is therefore valid one cycle after the address is applied.
- Read-during-write to the same address: ram_q gets the old word.

General:
- Addresses wrap naturally within 5 bits; no out-of-range case exists.
- Regfile and RAM writes in the same cycle are independent and both take effect.

Decomposition:
- Shared package storage_pkg holds DATA_W, ADDR_W, the NOP constant 0x00000013, and the ROM image as a constant array.
- One sub-module is natural: storage_array, an async-reset 32x32 flop array with one write port, instantiated twice.
  - Regfile instance: zero-index write masked; read muxes outside the array.
  - RAM instance: registered read output.
- The ROM is a case/const lookup in the wrapper.

Test Plan:
1. Reset then read all indices -> read_data1/2 = 0 for every index; ram_q = 0 one cycle after any address.
2. Write x1=5, x2=7 on two edges. Set read_reg1=1, read_reg2=2 -> read_data1=5, read_data2=7. Reading x1 in the write cycle before the edge -> 0.
3. write_enable=1, write_reg=0, write_data=0xDEADBEEF -> read_data1 with read_reg1=0 stays 0.
4. Sweep rom_pc 0..8 -> 0x00500093, 0x00700113, 0x002081B3, 0x00302223, 0x00118213, 0x00402423, 0x003202B3, 0x00000013, 0x00000013. rom_pc=31 -> 0x00000013.
5. RAM: write 12 to address 4, then hold address 4 with wren=0 -> ram_q=12 after the next edge. Same-edge read-during-write to address 8 with data 13 -> ram_q shows the old 0, then 13 on the following edge.
6. Assert rst mid-sequence between clock edges after writes -> all registers, RAM words and ram_q read 0 immediately, without waiting for a clock edge.
